// File: rtl/toy_pack.sv
// Shared types and default geometry for the icache data-RAM scheduler.
package toy_pack;

  localparam int BEATS      = 4;
  localparam int STARVE_MAX = 8;

  localparam int DEF_WAY_W   = 1;
  localparam int DEF_INDEX_W = 7;
  localparam int DEF_BEAT_W  = 2;
  localparam int DEF_DATA_W  = 128;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fsm_state_e;

  // Sized for the default geometry.
  typedef struct packed {
    logic [DEF_WAY_W-1:0]   way;
    logic [DEF_INDEX_W-1:0] index;
    logic [DEF_BEAT_W-1:0]  beat;
    logic [DEF_DATA_W-1:0]  wdata;
    logic                   we;
  } dataram_req_t;

endpackage

// File: rtl/icache_sat_counter.sv
// Saturating up-counter with clear; flags when the limit is reached.
module icache_sat_counter #(
  parameter int  MAX = 8,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic max
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign max = (cnt_q == W'(MAX));

endmodule

// File: rtl/icache_dataram_sched.sv
// Arbitrates hit reads and linefill beats onto the single icache data RAM port.
module icache_dataram_sched #(
  parameter int  WAY_NUM    = 2,
  parameter int  INDEX_W    = 7,
  parameter int  TXNID_W    = 5,
  parameter int  DATA_W     = 128,
  parameter int  BEATS      = toy_pack::BEATS,
  parameter int  STARVE_MAX = toy_pack::STARVE_MAX,
  localparam int WAY_W      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [WAY_W-1:0]   rd_way,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TXNID_W-1:0] rd_txnid,
  input  logic               lf_vld,
  output logic               lf_rdy,
  input  logic [WAY_W-1:0]   lf_way,
  input  logic [INDEX_W-1:0] lf_index,
  input  logic [DATA_W-1:0]  lf_data,
  input  logic               lf_last,
  output logic               ram_en,
  output logic               ram_we,
  output logic [WAY_W-1:0]   ram_way,
  output logic [INDEX_W-1:0] ram_index,
  output logic [BEAT_W-1:0]  ram_beat,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               rsp_vld,
  output logic [TXNID_W-1:0] rsp_txnid,
  output logic               lf_done,
  output logic [INDEX_W-1:0] lf_done_index,
  output logic               err_beat
);

  import toy_pack::*;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  fsm_state_e         state_q, state_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic               rsp_vld_q, rsp_vld_d;
  logic [TXNID_W-1:0] rsp_txnid_q, rsp_txnid_d;
  logic               lf_done_q, lf_done_d;
  logic [INDEX_W-1:0] lf_done_index_q, lf_done_index_d;
  logic               err_beat_q, err_beat_d;

  logic               idle;
  logic               starve_max;
  logic               rd_gnt;
  logic               lf_gnt;
  logic               lf_end;
  logic               beat_err;
  logic [BEAT_W-1:0]  cur_beat;
  logic [WAY_W-1:0]   fill_way;
  logic [INDEX_W-1:0] fill_index;
  dataram_req_t       req;

  assign idle = (state_q == IDLE);

  // Once starved, a pending fill blocks reads; otherwise reads take priority.
  assign rd_rdy = !rst && idle && !(starve_max && lf_vld);
  assign lf_rdy = !rst && (!idle || !rd_vld || starve_max);

  assign rd_gnt = rd_vld && rd_rdy;
  assign lf_gnt = lf_vld && lf_rdy;

  assign cur_beat   = idle ? '0 : beat_cnt_q;
  assign fill_way   = idle ? lf_way : way_q;
  assign fill_index = idle ? lf_index : index_q;
  assign lf_end     = lf_gnt && (lf_last || (cur_beat == LAST_BEAT));
  assign beat_err   = lf_gnt && (lf_last != (cur_beat == LAST_BEAT));

  icache_sat_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (idle && lf_vld && !lf_gnt),
    .clr (idle && lf_gnt),
    .max (starve_max)
  );

  always_comb begin
    req = '0;
    if (lf_gnt) begin
      req.we    = 1'b1;
      req.way   = DEF_WAY_W'(fill_way);
      req.index = DEF_INDEX_W'(fill_index);
      req.beat  = DEF_BEAT_W'(cur_beat);
      req.wdata = DEF_DATA_W'(lf_data);
    end else begin
      req.way   = DEF_WAY_W'(rd_way);
      req.index = DEF_INDEX_W'(rd_index);
    end
  end

  assign ram_en    = rd_gnt || lf_gnt;
  assign ram_we    = req.we;
  assign ram_way   = WAY_W'(req.way);
  assign ram_index = INDEX_W'(req.index);
  assign ram_beat  = BEAT_W'(req.beat);
  assign ram_wdata = DATA_W'(req.wdata);

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    way_d           = way_q;
    index_d         = index_q;
    rsp_vld_d       = rd_gnt;
    rsp_txnid_d     = rd_gnt ? rd_txnid : rsp_txnid_q;
    lf_done_d       = lf_end;
    lf_done_index_d = lf_end ? fill_index : lf_done_index_q;
    err_beat_d      = err_beat_q || beat_err;
    case (state_q)
      IDLE: begin
        if (lf_gnt && !lf_end) begin
          state_d    = FILL;
          beat_cnt_d = BEAT_W'(1);
          way_d      = lf_way;
          index_d    = lf_index;
        end
      end
      FILL: begin
        if (lf_end) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (lf_gnt) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      beat_cnt_q      <= '0;
      way_q           <= '0;
      index_q         <= '0;
      rsp_vld_q       <= 1'b0;
      rsp_txnid_q     <= '0;
      lf_done_q       <= 1'b0;
      lf_done_index_q <= '0;
      err_beat_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      way_q           <= way_d;
      index_q         <= index_d;
      rsp_vld_q       <= rsp_vld_d;
      rsp_txnid_q     <= rsp_txnid_d;
      lf_done_q       <= lf_done_d;
      lf_done_index_q <= lf_done_index_d;
      err_beat_q      <= err_beat_d;
    end
  end

  assign rsp_vld       = rsp_vld_q;
  assign rsp_txnid     = rsp_txnid_q;
  assign lf_done       = lf_done_q;
  assign lf_done_index = lf_done_index_q;
  assign err_beat      = err_beat_q;

endmodule

// File: tb/tb_icache_dataram_sched.sv
// Directed vector bench for icache_dataram_sched.
module tb_icache_dataram_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_vld;
  logic         rd_rdy;
  logic [0:0]   rd_way;
  logic [6:0]   rd_index;
  logic [4:0]   rd_txnid;
  logic         lf_vld;
  logic         lf_rdy;
  logic [0:0]   lf_way;
  logic [6:0]   lf_index;
  logic [127:0] lf_data;
  logic         lf_last;
  logic         ram_en;
  logic         ram_we;
  logic [0:0]   ram_way;
  logic [6:0]   ram_index;
  logic [1:0]   ram_beat;
  logic [127:0] ram_wdata;
  logic         rsp_vld;
  logic [4:0]   rsp_txnid;
  logic         lf_done;
  logic [6:0]   lf_done_index;
  logic         err_beat;

  int checks = 0;
  int errors = 0;

  icache_dataram_sched dut (
    .clk           (clk),
    .rst           (rst),
    .rd_vld        (rd_vld),
    .rd_rdy        (rd_rdy),
    .rd_way        (rd_way),
    .rd_index      (rd_index),
    .rd_txnid      (rd_txnid),
    .lf_vld        (lf_vld),
    .lf_rdy        (lf_rdy),
    .lf_way        (lf_way),
    .lf_index      (lf_index),
    .lf_data       (lf_data),
    .lf_last       (lf_last),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_way       (ram_way),
    .ram_index     (ram_index),
    .ram_beat      (ram_beat),
    .ram_wdata     (ram_wdata),
    .rsp_vld       (rsp_vld),
    .rsp_txnid     (rsp_txnid),
    .lf_done       (lf_done),
    .lf_done_index (lf_done_index),
    .err_beat      (err_beat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rdv;
    logic [6:0] ridx;
    logic [4:0] rtx;
    logic       lfv;
    logic       lway;
    logic [6:0] lidx;
    logic       last;
    logic       e_rr;
    logic       e_lr;
    logic       e_en;
    logic       e_we;
    logic       e_way;
    logic [6:0] e_idx;
    logic [1:0] e_beat;
    logic       e_rsp;
    logic [4:0] e_tx;
    logic       e_done;
    logic [6:0] e_didx;
    logic       e_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic rdv, input logic [6:0] ridx, input logic [4:0] rtx,
    input logic lfv, input logic lway, input logic [6:0] lidx,
    input logic last,
    input logic e_rr, input logic e_lr, input logic e_en, input logic e_we,
    input logic e_way, input logic [6:0] e_idx, input logic [1:0] e_beat,
    input logic e_rsp, input logic [4:0] e_tx,
    input logic e_done, input logic [6:0] e_didx, input logic e_err);
    vec_t t;
    t.rdv = rdv; t.ridx = ridx; t.rtx = rtx;
    t.lfv = lfv; t.lway = lway; t.lidx = lidx; t.last = last;
    t.e_rr = e_rr; t.e_lr = e_lr; t.e_en = e_en; t.e_we = e_we;
    t.e_way = e_way; t.e_idx = e_idx; t.e_beat = e_beat;
    t.e_rsp = e_rsp; t.e_tx = e_tx;
    t.e_done = e_done; t.e_didx = e_didx; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    return {96'h0, 32'(k) * 32'h0101_1111 + 32'h5};
  endfunction

  task automatic drive(input logic rdv, input logic [6:0] ridx,
                       input logic [4:0] rtx, input logic lfv,
                       input logic lway, input logic [6:0] lidx,
                       input logic last, input int k);
    rd_vld   = rdv;
    rd_way   = 1'b1;
    rd_index = ridx;
    rd_txnid = rtx;
    lf_vld   = lfv;
    lf_way   = lway;
    lf_index = lidx;
    lf_last  = last;
    lf_data  = pat(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int k);
    drive(t.rdv, t.ridx, t.rtx, t.lfv, t.lway, t.lidx, t.last, k);
    #1;
    chk($sformatf("v%0d rd_rdy", k), 128'(rd_rdy), 128'(t.e_rr));
    chk($sformatf("v%0d lf_rdy", k), 128'(lf_rdy), 128'(t.e_lr));
    chk($sformatf("v%0d ram_en", k), 128'(ram_en), 128'(t.e_en));
    if (t.e_en) begin
      chk($sformatf("v%0d ram_we", k), 128'(ram_we), 128'(t.e_we));
      chk($sformatf("v%0d ram_way", k), 128'(ram_way), 128'(t.e_way));
      chk($sformatf("v%0d ram_index", k), 128'(ram_index), 128'(t.e_idx));
    end
    if (t.e_we) begin
      chk($sformatf("v%0d ram_beat", k), 128'(ram_beat), 128'(t.e_beat));
      chk($sformatf("v%0d ram_wdata", k), ram_wdata, pat(k));
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rsp_vld", k), 128'(rsp_vld), 128'(t.e_rsp));
    chk($sformatf("v%0d rsp_txnid", k), 128'(rsp_txnid), 128'(t.e_tx));
    chk($sformatf("v%0d lf_done", k), 128'(lf_done), 128'(t.e_done));
    chk($sformatf("v%0d done_idx", k), 128'(lf_done_index),
        128'(t.e_didx));
    chk($sformatf("v%0d err_beat", k), 128'(err_beat), 128'(t.e_err));
  endtask

  initial begin
    vecs[0]  = mk(1, 7'h12, 3, 0, 0, 0, 0,
                  1, 0, 1, 0, 1, 7'h12, 0, 1, 3, 0, 0, 0);
    vecs[1]  = mk(1, 7'h20, 7, 0, 0, 0, 0,
                  1, 0, 1, 0, 1, 7'h20, 0, 1, 7, 0, 0, 0);
    vecs[2]  = mk(1, 7'h21, 8, 0, 0, 0, 0,
                  1, 0, 1, 0, 1, 7'h21, 0, 1, 8, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,
                  1, 1, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 7'h05, 0,
                  1, 1, 1, 1, 0, 7'h05, 0, 0, 8, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 7'h33, 0,
                  0, 1, 1, 1, 0, 7'h05, 1, 0, 8, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 7'h33, 0,
                  0, 1, 1, 1, 0, 7'h05, 2, 0, 8, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 1, 7'h33, 1,
                  0, 1, 1, 1, 0, 7'h05, 3, 0, 8, 1, 7'h05, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,
                  1, 1, 0, 0, 0, 0, 0, 0, 8, 0, 7'h05, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 7'h0A, 0,
                  1, 1, 1, 1, 0, 7'h0A, 0, 0, 8, 0, 7'h05, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 7'h44, 0,
                  0, 1, 1, 1, 0, 7'h0A, 1, 0, 8, 0, 7'h05, 0);
    vecs[11] = mk(1, 7'h30, 9, 0, 0, 0, 0,
                  0, 1, 0, 0, 0, 0, 0, 0, 8, 0, 7'h05, 0);
    vecs[12] = mk(1, 7'h30, 9, 0, 0, 0, 0,
                  0, 1, 0, 0, 0, 0, 0, 0, 8, 0, 7'h05, 0);
    vecs[13] = mk(1, 7'h30, 9, 1, 1, 7'h44, 0,
                  0, 1, 1, 1, 0, 7'h0A, 2, 0, 8, 0, 7'h05, 0);
    vecs[14] = mk(1, 7'h30, 9, 1, 1, 7'h44, 1,
                  0, 1, 1, 1, 0, 7'h0A, 3, 0, 8, 1, 7'h0A, 0);
    vecs[15] = mk(1, 7'h30, 9, 0, 0, 0, 0,
                  1, 0, 1, 0, 1, 7'h30, 0, 1, 9, 0, 7'h0A, 0);

    rst = 1'b1;
    drive(1, 7'h12, 3, 1, 0, 7'h05, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst rd_rdy", 128'(rd_rdy), 0);
    chk("rst lf_rdy", 128'(lf_rdy), 0);
    chk("rst ram_en", 128'(ram_en), 0);
    chk("rst rsp_vld", 128'(rsp_vld), 0);
    chk("rst rsp_txnid", 128'(rsp_txnid), 0);
    chk("rst lf_done", 128'(lf_done), 0);
    chk("rst done_idx", 128'(lf_done_index), 0);
    chk("rst err_beat", 128'(err_beat), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int k = 0; k < 16; k++) begin
      apply(vecs[k], k);
    end

    // Starvation: reads win STARVE_MAX times, then the fill takes over.
    for (int i = 0; i < 8; i++) begin
      drive(1, 7'(i), 5'(i + 16), 1, 0, 7'h07, 0, 100);
      #1;
      chk($sformatf("starve%0d rd_rdy", i), 128'(rd_rdy), 1);
      chk($sformatf("starve%0d lf_rdy", i), 128'(lf_rdy), 0);
      chk($sformatf("starve%0d ram_we", i), 128'(ram_we), 0);
      tick();
      chk($sformatf("starve%0d txnid", i), 128'(rsp_txnid), 128'(i + 16));
    end
    for (int b = 0; b < 4; b++) begin
      drive(1, 7'h01, 5'h01, 1, 0, 7'h07, logic'(b == 3), 200 + b);
      #1;
      chk($sformatf("sfill%0d rd_rdy", b), 128'(rd_rdy), 0);
      chk($sformatf("sfill%0d lf_rdy", b), 128'(lf_rdy), 1);
      chk($sformatf("sfill%0d ram_we", b), 128'(ram_we), 1);
      chk($sformatf("sfill%0d ram_beat", b), 128'(ram_beat), 128'(b));
      chk($sformatf("sfill%0d ram_index", b), 128'(ram_index), 7'h07);
      tick();
      chk($sformatf("sfill%0d rsp_vld", b), 128'(rsp_vld), 0);
    end
    chk("sfill lf_done", 128'(lf_done), 1);
    chk("sfill done_idx", 128'(lf_done_index), 7'h07);
    drive(1, 7'h02, 5'h02, 0, 0, 0, 0, 0);
    #1;
    chk("post-starve rd_rdy", 128'(rd_rdy), 1);
    tick();
    chk("post-starve rsp_txnid", 128'(rsp_txnid), 2);

    // Early lf_last on beat 1.
    drive(0, 0, 0, 1, 0, 7'h0C, 0, 300);
    tick();
    drive(0, 0, 0, 1, 0, 7'h0C, 1, 301);
    #1;
    chk("err ram_beat", 128'(ram_beat), 1);
    tick();
    chk("err err_beat", 128'(err_beat), 1);
    drive(1, 7'h03, 5'h11, 0, 0, 0, 0, 0);
    #1;
    chk("err rd_rdy", 128'(rd_rdy), 1);
    chk("err ram_we", 128'(ram_we), 0);
    tick();
    chk("err rsp_vld", 128'(rsp_vld), 1);
    chk("err rsp_txnid", 128'(rsp_txnid), 5'h11);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("err sticky", 128'(err_beat), 1);

    // Reset after beat 2 of a fill.
    for (int b = 0; b < 3; b++) begin
      drive(0, 0, 0, 1, 0, 7'h15, 0, 400 + b);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mrst rd_rdy", 128'(rd_rdy), 0);
    chk("mrst lf_rdy", 128'(lf_rdy), 0);
    chk("mrst ram_en", 128'(ram_en), 0);
    chk("mrst rsp_txnid", 128'(rsp_txnid), 0);
    chk("mrst err_beat", 128'(err_beat), 0);
    chk("mrst done_idx", 128'(lf_done_index), 0);
    tick();
    chk("mrst lf_done", 128'(lf_done), 0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 7'h16, 0, 500);
    #1;
    chk("mrst new beat", 128'(ram_beat), 0);
    chk("mrst new index", 128'(ram_index), 7'h16);
    chk("mrst new we", 128'(ram_we), 1);
    tick();
    chk("mrst no done", 128'(lf_done), 0);
    drive(0, 0, 0, 1, 0, 7'h20, 0, 501);
    #1;
    chk("mrst beat1", 128'(ram_beat), 1);
    chk("mrst beat1 idx", 128'(ram_index), 7'h16);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dataram_sched.md
ICACHE_DATARAM_SCHED -- requirements
Module: icache_dataram_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter WAY_NUM, default 2, giving the number of ways; the way field width is WAY_W = clog2(WAY_NUM).
REQ-002 The block SHALL have parameter INDEX_W, default 7, giving the set-index width.
REQ-003 The block SHALL have parameter TXNID_W, default 5, giving the upstream txnid width.
REQ-004 The block SHALL have parameter DATA_W, default 128, giving the linefill beat width.
REQ-005 The block SHALL have parameter BEATS, default 4, giving linefill beats per line; the beat index width is BEAT_W = clog2(BEATS).
REQ-006 The block SHALL have parameter STARVE_MAX, default 8, giving the fill-wait limit in cycles before a fill overrides reads.

Ports (name, direction, width, meaning):
REQ-007 The block SHALL have these clock and reset ports:
- clk, in, 1, sole clock;
- rst, in, 1, asynchronous active-high reset.
REQ-008 The block SHALL have these hit-read request ports:
- rd_vld, in, 1;
- rd_rdy, out, 1;
- rd_way, in, WAY_W;
- rd_index, in, INDEX_W;
- rd_txnid, in, TXNID_W.
REQ-009 The block SHALL have these linefill beat ports:
- lf_vld, in, 1;
- lf_rdy, out, 1;
- lf_way, in, WAY_W;
- lf_index, in, INDEX_W;
- lf_data, in, DATA_W;
- lf_last, in, 1.
REQ-010 The block SHALL have these RAM port signals:
- ram_en, out, 1;
- ram_we, out, 1;
- ram_way, out, WAY_W;
- ram_index, out, INDEX_W;
- ram_beat, out, BEAT_W;
- ram_wdata, out, DATA_W.
REQ-011 The block SHALL have these response and status ports:
- rsp_vld, out, 1, read data valid from the RAM this cycle;
- rsp_txnid, out, TXNID_W;
- lf_done, out, 1, one-cycle pulse;
- lf_done_index, out, INDEX_W;
- err_beat, out, 1, sticky.

Function
REQ-012 The FSM SHALL have the states IDLE and FILL.
REQ-013 A transfer SHALL occur only when vld and rdy are both high in the same cycle; rdy SHALL NOT depend combinationally on any vld other than its own arbitration.
REQ-014 In IDLE, the read SHALL be granted when rd_vld=1 and starve_cnt<STARVE_MAX; otherwise the fill SHALL be granted when lf_vld=1.
REQ-015 A fill grant in IDLE SHALL write beat 0, latch lf_way and lf_index, and go to FILL, unless lf_last=1.
REQ-016 In FILL, rd_rdy SHALL be 0, and lf_rdy SHALL be 1.
REQ-017 Each accepted beat in FILL SHALL drive ram_en=1, ram_we=1, ram_beat=beat_cnt and ram_wdata=lf_data, and SHALL increment beat_cnt.
REQ-018 A bubble in FILL (lf_vld=0) SHALL drive ram_en=0 and keep the state FILL.
REQ-019 An accepted beat with lf_last=1 SHALL return the FSM to IDLE, clear beat_cnt, and pulse lf_done with lf_done_index one cycle later.
REQ-020 err_beat SHALL set if lf_last=1 with beat_cnt!=BEATS-1, or if beat_cnt=BEATS-1 with lf_last=0.
REQ-021 On either error condition the FSM SHALL still exit to IDLE.
REQ-022 lf_way and lf_index SHALL be ignored after beat 0.
REQ-023 A read grant SHALL drive ram_en=1, ram_we=0, ram_way=rd_way and ram_index=rd_index.
REQ-024 A read grant SHALL produce rsp_vld=1 with rsp_txnid registered exactly 1 cycle later.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, each IDLE cycle with lf_vld=1 and no fill grant, and SHALL clear on a fill grant.
REQ-026 When rd_vld=1 and lf_vld=1 arrive in the same cycle with starve_cnt=STARVE_MAX, the fill SHALL win and rd_rdy SHALL be 0.
REQ-027 ram_en SHALL be at most one access per cycle; a read and a write SHALL never occur in the same cycle.
REQ-028 Back-to-back reads SHALL sustain 1 per cycle.

Reset
REQ-029 While rst=1, the block SHALL hold: state=IDLE, beat_cnt=0, starve_cnt=0, rsp_vld=0, rsp_txnid=0, lf_done=0, lf_done_index=0, err_beat=0.
REQ-030 Asserting rst mid-FILL SHALL abandon the line with no lf_done pulse.
REQ-031 With rst=1, ram_en, rd_rdy and lf_rdy SHALL be 0.

Structure
REQ-032 The types fsm_state_e and dataram_req_t (way, index, beat, wdata, we), and the default constants BEATS and STARVE_MAX, SHALL live in toy_pack.
REQ-033 The starvation counter SHALL be one sub-module, icache_sat_counter, holding a saturating counter with inc/clr inputs and a max output.
REQ-034 The remainder SHALL be flat, at 150-250 lines.

Verification
REQ-035 Single read: rd_vld with way 1, index 0x12, txnid 3 -> same cycle ram_en=1, ram_we=0, ram_index=0x12; next cycle rsp_vld=1 with rsp_txnid=3.
REQ-036 Clean fill: 4 consecutive beats at index 0x05 with lf_last on beat 3 -> ram_beat 0,1,2,3 with ram_we=1; lf_done=1 and lf_done_index=0x05 one cycle after beat 3; err_beat=0.
REQ-037 Starvation: rd_vld held high with lf_vld high -> 8 read grants, then the fill is granted in cycle 9 and rd_rdy=0 until lf_last.
REQ-038 Bubble mid-fill: lf_vld drops for 2 cycles after beat 1 -> ram_en=0 for those cycles, then beats 2 and 3 complete, and reads stay blocked throughout.
REQ-039 Protocol error: lf_last on beat 1 -> err_beat=1 (sticky), FSM in IDLE, and the next read is accepted.
REQ-040 Reset mid-fill: rst pulse after beat 2 -> no lf_done, all outputs at reset values, and a new fill starts at beat 0.
